// File: rtl/serialize_pkg.sv
// Shared types and sizes for the frame serializer and its parse partner.
// Holds FSM states, header/pixel byte counts and the header byte selector.
package serialize_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      PIX_R = 3'd2,
      PIX_G = 3'd3,
      PIX_B = 3'd4,
      FLUSH = 3'd5
   } state_t;

   localparam int HDR_BYTES       = 4;
   localparam int BYTES_PER_PIXEL = 3;

   // Header order: height lo, height hi, width lo, width hi.
   function automatic logic [7:0] hdr_byte(
      input logic [1:0]  idx,
      input logic [15:0] h,
      input logic [15:0] w
   );
      logic [7:0] b;
      unique case (idx)
         2'd0:    b = h[7:0];
         2'd1:    b = h[15:8];
         2'd2:    b = w[7:0];
         default: b = w[15:8];
      endcase
      return b;
   endfunction

   // Bytes on the link for a frame of 'total' pixels.
   function automatic logic [33:0] frame_bytes(input logic [31:0] total);
      return 34'(HDR_BYTES) + 34'(BYTES_PER_PIXEL) * {2'b00, total};
   endfunction

endpackage

// File: rtl/serialize_if.sv
// Handshake bundle of the serializer: frame request, pixel stream in,
// byte stream out, status. slave = serializer, master = its environment.
interface serialize_if;
   logic        start;
   logic [15:0] height;
   logic [15:0] width;
   logic [7:0]  pixel_r;
   logic [7:0]  pixel_g;
   logic [7:0]  pixel_b;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        data_ready;
   logic        busy;
   logic        done;

   modport slave (
      input  start, height, width,
      input  pixel_r, pixel_g, pixel_b, pixel_valid,
      output pixel_ready,
      output data_out, data_valid,
      input  data_ready,
      output busy, done
   );

   modport master (
      output start, height, width,
      output pixel_r, pixel_g, pixel_b, pixel_valid,
      input  pixel_ready,
      input  data_out, data_valid,
      output data_ready,
      input  busy, done
   );
endinterface

// File: rtl/serialize.sv
// Frame serializer: 4 header bytes (h lo/hi, w lo/hi) then R,G,B per pixel.
// Ports: clk, reset (sync, active-high), bus (serialize_if.slave).
module serialize
   import serialize_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   serialize_if.slave bus
);

   state_t      state;
   logic [1:0]  hdr_idx;
   logic [15:0] h_q;
   logic [15:0] w_q;
   logic [31:0] total;
   logic [31:0] pix_cnt;
   logic [7:0]  g_q;
   logic [7:0]  b_q;
   logic [7:0]  dout_q;
   logic        dv_q;
   logic        done_q;
   logic        free;
   logic        pix_acc;

   // Output register may take a new byte when empty or being drained.
   assign free    = !dv_q || bus.data_ready;
   assign pix_acc = (state == PIX_R) && free && bus.pixel_valid;

   assign bus.pixel_ready = (state == PIX_R) && free;
   assign bus.data_out    = dout_q;
   assign bus.data_valid  = dv_q;
   assign bus.busy        = (state != IDLE);
   assign bus.done        = done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         hdr_idx <= 2'd0;
         h_q     <= 16'd0;
         w_q     <= 16'd0;
         total   <= 32'd0;
         pix_cnt <= 32'd0;
         g_q     <= 8'd0;
         b_q     <= 8'd0;
         dout_q  <= 8'd0;
         dv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Product settles one cycle after capture; HDR spans 3 cycles.
         total  <= 32'(h_q) * 32'(w_q);
         if (free) dv_q <= 1'b0;

         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  h_q     <= bus.height;
                  w_q     <= bus.width;
                  pix_cnt <= 32'd0;
                  hdr_idx <= 2'd1;
                  dout_q  <= bus.height[7:0];
                  dv_q    <= 1'b1;
                  state   <= HDR;
               end
            end
            HDR: begin
               if (free) begin
                  dout_q  <= hdr_byte(hdr_idx, h_q, w_q);
                  dv_q    <= 1'b1;
                  hdr_idx <= hdr_idx + 2'd1;
                  if (hdr_idx == 2'(HDR_BYTES - 1))
                     state <= (total != 32'd0) ? PIX_R : FLUSH;
               end
            end
            PIX_R: begin
               if (pix_acc) begin
                  dout_q <= bus.pixel_r;
                  g_q    <= bus.pixel_g;
                  b_q    <= bus.pixel_b;
                  dv_q   <= 1'b1;
                  state  <= PIX_G;
               end
            end
            PIX_G: begin
               if (free) begin
                  dout_q <= g_q;
                  dv_q   <= 1'b1;
                  state  <= PIX_B;
               end
            end
            PIX_B: begin
               if (free) begin
                  dout_q  <= b_q;
                  dv_q    <= 1'b1;
                  pix_cnt <= pix_cnt + 32'd1;
                  if (pix_cnt + 32'd1 == total)
                     state <= FLUSH;
                  else
                     state <= PIX_R;
               end
            end
            FLUSH: begin
               if (free) begin
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serialize.sv
// Scoreboard bench for serialize: expected bytes queued at frame start,
// popped and compared by a monitor on every byte transfer.
module tb_serialize;
   import serialize_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   serialize_if bus ();

   serialize dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0]  byte_q[$];
   logic [23:0] pix_q[$];

   int  rdy_mode = 0;
   bit  gap_en   = 0;
   bit  px_took  = 0;
   bit  stall_prev = 0;
   logic [7:0] prev_byte = 8'd0;
   bit  expect_done = 0;
   bit  pr_seen = 0;
   int  xfer_cnt = 0;
   int  done_cnt = 0;
   int  done_cyc = 0;
   int  start_cyc = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Source and sink driver, updated just after each edge.
   always @(negedge clk)
      px_took = bus.pixel_valid && bus.pixel_ready && !reset;

   always @(posedge clk) begin
      bit hold;
      #1;
      if (px_took && pix_q.size() > 0) void'(pix_q.pop_front());
      hold = bus.pixel_valid && !px_took;
      if (pix_q.size() == 0) begin
         bus.pixel_valid = 1'b0;
      end else begin
         bus.pixel_valid = hold || !gap_en || ($urandom_range(0, 2) != 0);
         {bus.pixel_r, bus.pixel_g, bus.pixel_b} = pix_q[0];
      end
      case (rdy_mode)
         0:       bus.data_ready = 1'b1;
         1:       bus.data_ready = ~bus.data_ready;
         default: bus.data_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: byte transfers, output stability, done pulse placement.
   always @(negedge clk) begin
      if (reset) begin
         stall_prev  = 0;
         expect_done = 0;
      end else begin
         if (bus.pixel_ready) pr_seen = 1;
         if (stall_prev)
            check("stable", 32'({bus.data_valid, bus.data_out}),
                  32'({1'b1, prev_byte}));
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (expect_done) begin
            check("done_pulse", 32'({bus.done, bus.busy}), 32'b10);
            expect_done = 0;
         end else if (bus.done) begin
            check("spurious_done", 32'(bus.done), 32'd0);
         end
         if (bus.data_valid && bus.data_ready) begin
            xfer_cnt++;
            if (byte_q.size() == 0) begin
               check("extra_byte", 32'(bus.data_out), 32'hFFFF_FFFF);
            end else begin
               check("byte", 32'(bus.data_out), 32'(byte_q.pop_front()));
               if (byte_q.size() == 0) expect_done = 1;
            end
         end
         stall_prev = bus.data_valid && !bus.data_ready;
         prev_byte  = bus.data_out;
      end
   end

   // Reference: header bytes then each pixel's R,G,B, in acceptance order.
   task automatic start_frame(input logic [15:0] h, input logic [15:0] w,
                              input bit fixed);
      int n;
      logic [23:0] px;
      n = int'(h) * int'(w);
      byte_q.push_back(h[7:0]);
      byte_q.push_back(h[15:8]);
      byte_q.push_back(w[7:0]);
      byte_q.push_back(w[15:8]);
      for (int i = 0; i < n; i++) begin
         px = fixed ? 24'h102030 + 24'(i) * 24'h303030 : 24'($urandom);
         pix_q.push_back(px);
         byte_q.push_back(px[23:16]);
         byte_q.push_back(px[15:8]);
         byte_q.push_back(px[7:0]);
      end
      bus.height = h;
      bus.width  = w;
      bus.start  = 1'b1;
      start_cyc  = cyc;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.height = 16'($urandom);
      bus.width  = 16'($urandom);
      @(negedge clk);
      check("first_byte",
            32'({bus.data_valid, bus.busy, bus.data_out}),
            32'({1'b1, 1'b1, h[7:0]}));
   endtask

   task automatic wait_done(input int prev, input int budget);
      int n = 0;
      while (done_cnt == prev && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_seen", 32'(done_cnt != prev), 32'd1);
   endtask

   task automatic run_frame(input logic [15:0] h, input logic [15:0] w,
                            input bit fixed, input int mode, input bit gaps);
      int prev;
      int n;
      n = int'(h) * int'(w);
      rdy_mode = mode;
      gap_en   = gaps;
      @(posedge clk); #1;
      @(posedge clk); #1;
      prev = done_cnt;
      start_frame(h, w, fixed);
      wait_done(prev, 100 + 8 * int'(frame_bytes(32'(n))));
      if (mode == 0 && !gaps)
         check("gapless_latency", 32'(done_cyc - start_cyc),
               32'(5 + 3 * n));
      check("queue_drained", 32'(byte_q.size()), 32'd0);
   endtask

   initial begin
      int prev;
      int base;
      int n;
      #50_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int prev;
      int base;
      int n;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.height = 16'd0;
      bus.width = 16'd0;
      bus.pixel_r = 8'd0;
      bus.pixel_g = 8'd0;
      bus.pixel_b = 8'd0;
      bus.pixel_valid = 1'b0;
      bus.data_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.start = 1'b1;
      @(negedge clk);
      check("rst_data_out", 32'(bus.data_out), 32'd0);
      check("rst_data_valid", 32'(bus.data_valid), 32'd0);
      check("rst_pixel_ready", 32'(bus.pixel_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      check("rst_beats_start", 32'({bus.busy, bus.done}), 32'd0);
      bus.start = 1'b0;
      reset = 1'b0;

      // 2x2 fixed frame, gapless, then with stalling sink.
      run_frame(16'd2, 16'd2, 1'b1, 0, 1'b0);
      run_frame(16'd2, 16'd2, 1'b1, 1, 1'b0);

      // Zero-size frame: header only, pixel offered but never taken.
      pix_q.push_back(24'hDEAD01);
      pr_seen = 0;
      run_frame(16'h0103, 16'd0, 1'b0, 0, 1'b0);
      check("zero_no_pixel_ready", 32'(pr_seen), 32'd0);
      check("zero_pixel_kept", 32'(pix_q.size()), 32'd1);
      pix_q.delete();

      // 1x1 frame with a second start at cycle 3.
      @(posedge clk); #1;
      rdy_mode = 0;
      gap_en = 0;
      prev = done_cnt;
      start_frame(16'd1, 16'd1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.height = 16'd9;
      bus.width = 16'd9;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(prev, 100);
      repeat (10) @(posedge clk);
      #1;
      check("one_done", 32'(done_cnt - prev), 32'd1);
      check("no_extra_bytes", 32'(byte_q.size()), 32'd0);

      // Abort a 2x1 frame after 6 bytes.
      prev = done_cnt;
      base = xfer_cnt;
      start_frame(16'd2, 16'd1, 1'b0);
      n = 0;
      while (xfer_cnt < base + 6 && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      check("abort_reached", 32'(xfer_cnt - base), 32'd6);
      reset = 1'b1;
      byte_q.delete();
      pix_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_state",
            32'({bus.data_valid, bus.busy, bus.done}), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt - prev), 32'd0);
      run_frame(16'd2, 16'd1, 1'b0, 0, 1'b0);

      // 3x2 random frame with source gaps and random sink.
      run_frame(16'd3, 16'd2, 1'b0, 2, 1'b1);

      // Random sizes, sink and source behaviour.
      for (int i = 0; i < 12; i++)
         run_frame(16'($urandom_range(0, 4)), 16'($urandom_range(0, 4)),
                   1'b0, int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)));

      repeat (4) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
